// File: rtl/dma_sim_stream_gen_if.sv
// Multi-channel AXI-Stream bundle: channel c occupies slice c of every vector.
interface dma_sim_stream_gen_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_CH*DATA_WIDTH-1:0]   tdata;
    logic [NUM_CH*DATA_WIDTH/8-1:0] tkeep;
    logic [NUM_CH-1:0]              tlast;
    logic [NUM_CH-1:0]              tvalid;
    logic [NUM_CH-1:0]              tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/dma_sim_stream_gen.sv
// N-channel counting-pattern AXI-Stream packet generator with per-channel
// handshaking, inter-packet gaps, packet counts and graceful stop.
module dma_sim_stream_gen #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  pkt_len_bytes,
    input  logic [15:0]           pkt_count,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    dma_sim_stream_gen_if.master  m_axis,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     done
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = DATA_WIDTH - 8;
    localparam int RW    = $clog2(BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    logic [RW-1:0]        rem_in;
    logic [LEN_WIDTH-1:0] beats_in;
    assign rem_in   = RW'(pkt_len_bytes % LEN_WIDTH'(BYTES));
    assign beats_in = (pkt_len_bytes / LEN_WIDTH'(BYTES)) + LEN_WIDTH'(rem_in != '0);

    function automatic logic [BYTES-1:0] keep_mask(input logic last, input logic [RW-1:0] rem);
        keep_mask = '1;
        for (int b = 0; b < BYTES; b++) begin
            if (last && rem != '0 && b >= int'(rem))
                keep_mask[b] = 1'b0;
        end
    endfunction

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t               state_reg, state_next;
        logic [CW-1:0]        beat_cnt_reg, beat_cnt_next;
        logic [LEN_WIDTH-1:0] beat_idx_reg, beat_idx_next;
        logic [LEN_WIDTH-1:0] beats_reg, beats_next;
        logic [RW-1:0]        rem_reg, rem_next;
        logic [15:0]          pkt_count_reg, pkt_count_next;
        logic [15:0]          pkts_sent_reg, pkts_sent_next;
        logic [GAP_WIDTH-1:0] gap_reg, gap_next;
        logic [GAP_WIDTH-1:0] gap_cnt_reg, gap_cnt_next;
        logic                 stop_pending_reg, stop_pending_next;
        logic                 tvalid_reg, tvalid_next;
        logic                 tlast_reg, tlast_next;
        logic                 busy_reg, busy_next;
        logic                 done_reg, done_next;
        logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
        logic [BYTES-1:0]     tkeep_reg, tkeep_next;
        logic                 load_beat, clear_beat;
        logic                 handshake;

        assign handshake = tvalid_reg & m_axis.tready[gi];

        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                state_reg        <= ST_IDLE;
                beat_cnt_reg     <= '0;
                beat_idx_reg     <= '0;
                beats_reg        <= '0;
                rem_reg          <= '0;
                pkt_count_reg    <= '0;
                pkts_sent_reg    <= '0;
                gap_reg          <= '0;
                gap_cnt_reg      <= '0;
                stop_pending_reg <= 1'b0;
                tvalid_reg       <= 1'b0;
                tlast_reg        <= 1'b0;
                busy_reg         <= 1'b0;
                done_reg         <= 1'b0;
                tdata_reg        <= '0;
                tkeep_reg        <= '0;
            end else begin
                state_reg        <= state_next;
                beat_cnt_reg     <= beat_cnt_next;
                beat_idx_reg     <= beat_idx_next;
                beats_reg        <= beats_next;
                rem_reg          <= rem_next;
                pkt_count_reg    <= pkt_count_next;
                pkts_sent_reg    <= pkts_sent_next;
                gap_reg          <= gap_next;
                gap_cnt_reg      <= gap_cnt_next;
                stop_pending_reg <= stop_pending_next;
                tvalid_reg       <= tvalid_next;
                tlast_reg        <= tlast_next;
                busy_reg         <= busy_next;
                done_reg         <= done_next;
                tdata_reg        <= tdata_next;
                tkeep_reg        <= tkeep_next;
            end
        end

        always_comb begin
            state_next        = state_reg;
            beat_cnt_next     = beat_cnt_reg;
            beat_idx_next     = beat_idx_reg;
            beats_next        = beats_reg;
            rem_next          = rem_reg;
            pkt_count_next    = pkt_count_reg;
            pkts_sent_next    = pkts_sent_reg;
            gap_next          = gap_reg;
            gap_cnt_next      = gap_cnt_reg;
            stop_pending_next = stop_pending_reg;
            tvalid_next       = tvalid_reg;
            tlast_next        = tlast_reg;
            tdata_next        = tdata_reg;
            tkeep_next        = tkeep_reg;
            done_next         = 1'b0;
            load_beat         = 1'b0;
            clear_beat        = 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start && pkt_len_bytes != '0) begin
                        beats_next        = beats_in;
                        rem_next          = rem_in;
                        pkt_count_next    = pkt_count;
                        gap_next          = gap_cycles;
                        pkts_sent_next    = '0;
                        stop_pending_next = 1'b0;
                        beat_cnt_next     = '0;
                        beat_idx_next     = LEN_WIDTH'(1);
                        state_next        = ST_SEND;
                        load_beat         = 1'b1;
                    end
                end
                ST_SEND: begin
                    if (stop)
                        stop_pending_next = 1'b1;
                    if (handshake) begin
                        beat_cnt_next = beat_cnt_reg + CW'(1);
                        if (tlast_reg) begin
                            if (pkts_sent_reg != 16'hFFFF)
                                pkts_sent_next = pkts_sent_reg + 16'd1;
                            if ((pkt_count_reg != '0 && pkts_sent_next == pkt_count_reg) ||
                                stop_pending_next) begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                                clear_beat = 1'b1;
                            end else if (gap_reg == '0) begin
                                beat_idx_next = LEN_WIDTH'(1);
                                load_beat     = 1'b1;
                            end else begin
                                state_next   = ST_GAP;
                                gap_cnt_next = gap_reg;
                                clear_beat   = 1'b1;
                            end
                        end else begin
                            beat_idx_next = beat_idx_reg + LEN_WIDTH'(1);
                            load_beat     = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // A stop during the gap has no packet in flight to finish.
                    if (stop) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (gap_cnt_reg <= GAP_WIDTH'(1)) begin
                        state_next    = ST_SEND;
                        beat_idx_next = LEN_WIDTH'(1);
                        load_beat     = 1'b1;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - GAP_WIDTH'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            if (load_beat) begin
                tvalid_next = 1'b1;
                tdata_next  = {8'(gi), beat_cnt_next};
                tlast_next  = (beat_idx_next == beats_next);
                tkeep_next  = keep_mask(tlast_next, rem_next);
            end else if (clear_beat) begin
                tvalid_next = 1'b0;
                tdata_next  = '0;
                tkeep_next  = '0;
                tlast_next  = 1'b0;
            end
            busy_next = (state_next != ST_IDLE);
        end

        assign m_axis.tdata[gi*DATA_WIDTH +: DATA_WIDTH] = tdata_reg;
        assign m_axis.tkeep[gi*BYTES +: BYTES]           = tkeep_reg;
        assign m_axis.tlast[gi]                          = tlast_reg;
        assign m_axis.tvalid[gi]                         = tvalid_reg;
        assign busy[gi]                                  = busy_reg;
        assign done[gi]                                  = done_reg;
    end
endmodule

// File: tb/tb_dma_sim_stream_gen.sv
// Directed bench for dma_sim_stream_gen with two 32-bit channels.
module tb_dma_sim_stream_gen;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] pkt_len_bytes = '0;
    logic [15:0] pkt_count = '0;
    logic [7:0]  gap_cycles = '0;
    logic [1:0]  busy, done;

    always #5 aclk = ~aclk;

    dma_sim_stream_gen_if #(.NUM_CH(2), .DATA_WIDTH(32)) axis_if ();

    dma_sim_stream_gen #(.NUM_CH(2), .DATA_WIDTH(32), .LEN_WIDTH(16), .GAP_WIDTH(8)) dut (
        .aclk(aclk), .areset(areset), .start(start), .stop(stop),
        .pkt_len_bytes(pkt_len_bytes), .pkt_count(pkt_count), .gap_cycles(gap_cycles),
        .m_axis(axis_if.master), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         len;
        int         exp_beats;
        logic [3:0] last_keep;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_pkt(input int len, input int cnt, input int gap);
        pkt_len_bytes = 16'(len);
        pkt_count     = 16'(cnt);
        gap_cycles    = 8'(gap);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int c, input int idx, input logic last,
                            input logic [3:0] keep);
        logic [31:0] exp_data;
        exp_data = {c[7:0], 24'(idx)};
        chk($sformatf("%s_ch%0d_valid", tag, c), 64'(axis_if.tvalid[c]), 64'd1);
        chk($sformatf("%s_ch%0d_data", tag, c), 64'(axis_if.tdata[c*32 +: 32]), 64'(exp_data));
        chk($sformatf("%s_ch%0d_last", tag, c), 64'(axis_if.tlast[c]), 64'(last));
        chk($sformatf("%s_ch%0d_keep", tag, c), 64'(axis_if.tkeep[c*4 +: 4]), 64'(keep));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, 64'(axis_if.tvalid), 64'd0);
        chk({tag, "_tdata"},  64'(axis_if.tdata),  64'd0);
        chk({tag, "_tkeep"},  64'(axis_if.tkeep),  64'd0);
        chk({tag, "_tlast"},  64'(axis_if.tlast),  64'd0);
        chk({tag, "_busy"},   64'(busy),           64'd0);
        chk({tag, "_done"},   64'(done),           64'd0);
    endtask

    initial begin
        int          idx [2];
        int          done_cnt [2];
        logic        stalled [2];
        logic [31:0] prev_data [2];
        logic        exp_v [11];
        int          d;

        vecs[0] = '{16, 4, 4'hF};
        vecs[1] = '{10, 3, 4'h3};
        vecs[2] = '{1,  1, 4'h1};
        vecs[3] = '{4,  1, 4'hF};
        vecs[4] = '{7,  2, 4'h7};
        vecs[5] = '{9,  3, 4'h1};
        exp_v   = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};

        axis_if.tready = 2'b11;
        step();
        step();
        chk_all_zero("reset");
        areset = 1'b0;
        step();
        chk_all_zero("idle");

        // Length-0 start must be ignored.
        start_pkt(0, 1, 0);
        chk("len0_busy", 64'(busy), 64'd0);
        $display("seq len0 start ignored");

        for (int v = 0; v < 6; v++) begin
            start_pkt(vecs[v].len, 1, 0);
            for (int i = 0; i < vecs[v].exp_beats; i++) begin
                for (int c = 0; c < 2; c++)
                    chk_beat($sformatf("vec%0d_b%0d", v, i), c, i, i == vecs[v].exp_beats - 1,
                             (i == vecs[v].exp_beats - 1) ? vecs[v].last_keep : 4'hF);
                chk($sformatf("vec%0d_b%0d_busy", v, i), 64'(busy), 64'd3);
                step();
            end
            chk($sformatf("vec%0d_done", v), 64'(done), 64'd3);
            chk($sformatf("vec%0d_busy_end", v), 64'(busy), 64'd0);
            chk($sformatf("vec%0d_valid_end", v), 64'(axis_if.tvalid), 64'd0);
            step();
            chk($sformatf("vec%0d_done_pulse", v), 64'(done), 64'd0);
            $display("vec %0d len=%0d beats=%0d last_keep=%h", v, vecs[v].len,
                     vecs[v].exp_beats, vecs[v].last_keep);
        end

        // Backpressure: ch0 ready toggles, ch1 ready held low for 5 cycles.
        start_pkt(16, 1, 0);
        for (int c = 0; c < 2; c++) begin
            idx[c] = 0; done_cnt[c] = 0; stalled[c] = 1'b0; prev_data[c] = '0;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            axis_if.tready[0] = cyc[0];
            axis_if.tready[1] = (cyc >= 5);
            for (int c = 0; c < 2; c++) begin
                if (axis_if.tvalid[c]) begin
                    chk($sformatf("bp_c%0d_ch%0d_data", cyc, c), 64'(axis_if.tdata[c*32 +: 32]),
                        64'({c[7:0], 24'(idx[c])}));
                    chk($sformatf("bp_c%0d_ch%0d_last", cyc, c), 64'(axis_if.tlast[c]),
                        64'(idx[c] == 3));
                    if (stalled[c])
                        chk($sformatf("bp_c%0d_ch%0d_stable", cyc, c),
                            64'(axis_if.tdata[c*32 +: 32]), 64'(prev_data[c]));
                end
                if (done[c]) done_cnt[c]++;
                stalled[c]   = axis_if.tvalid[c] & ~axis_if.tready[c];
                prev_data[c] = axis_if.tdata[c*32 +: 32];
                if (axis_if.tvalid[c] && axis_if.tready[c]) idx[c]++;
            end
            step();
        end
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("bp_ch%0d_beats", c), 64'(idx[c]), 64'd4);
            chk($sformatf("bp_ch%0d_dones", c), 64'(done_cnt[c]), 64'd1);
        end
        axis_if.tready = 2'b11;
        $display("seq backpressure ch0_beats=%0d ch1_beats=%0d", idx[0], idx[1]);

        // Three 2-beat packets separated by 2-cycle gaps.
        start_pkt(8, 3, 2);
        d = 0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            chk($sformatf("gap_c%0d_valid", cyc), 64'(axis_if.tvalid), exp_v[cyc] ? 64'd3 : 64'd0);
            if (exp_v[cyc]) begin
                for (int c = 0; c < 2; c++)
                    chk_beat($sformatf("gap_c%0d", cyc), c, d, d[0], 4'hF);
                d++;
            end
            chk($sformatf("gap_c%0d_done", cyc), 64'(done), (cyc == 10) ? 64'd3 : 64'd0);
            step();
        end
        $display("seq gap count=3 gap=2 beats=%0d", d);

        // Continuous mode, start while busy ignored, stop during beat 2 of packet 2.
        start_pkt(12, 0, 0);
        for (int cyc = 0; cyc < 6; cyc++) begin
            for (int c = 0; c < 2; c++)
                chk_beat($sformatf("stop_c%0d", cyc), c, cyc, (cyc % 3) == 2, 4'hF);
            if (cyc == 1) begin start = 1'b1; pkt_len_bytes = 16'd4; end
            if (cyc == 4) stop = 1'b1;
            step();
            start = 1'b0;
            stop  = 1'b0;
        end
        chk("stop_done", 64'(done), 64'd3);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_valid", 64'(axis_if.tvalid), 64'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop2_done", 64'(done), 64'd0);
        chk("stop2_busy", 64'(busy), 64'd0);
        $display("seq continuous stop after tlast");

        // Stop while in a gap ends the channel at once.
        start_pkt(4, 0, 5);
        for (int c = 0; c < 2; c++) chk_beat("gstop_b0", c, 0, 1'b1, 4'hF);
        step();
        chk("gstop_gap_valid", 64'(axis_if.tvalid), 64'd0);
        chk("gstop_gap_busy", 64'(busy), 64'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("gstop_done", 64'(done), 64'd3);
        chk("gstop_busy", 64'(busy), 64'd0);
        step();
        chk("gstop_done_pulse", 64'(done), 64'd0);
        $display("seq stop during gap");

        // Asynchronous reset mid-packet, then restart with start+stop together.
        start_pkt(16, 1, 0);
        step();
        step();
        for (int c = 0; c < 2; c++) chk_beat("ar_pre", c, 2, 1'b0, 4'hF);
        areset = 1'b1;
        #1;
        chk_all_zero("ar_now");
        step();
        areset = 1'b0;
        step();
        pkt_len_bytes = 16'd16;
        pkt_count     = 16'd2;
        gap_cycles    = 8'd0;
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 2; c++)
                chk_beat($sformatf("ar_b%0d", i), c, i, (i % 4) == 3, 4'hF);
            step();
        end
        chk("ar_done", 64'(done), 64'd3);
        chk("ar_busy", 64'(busy), 64'd0);
        $display("seq areset mid-packet and restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
